// File: rtl/regfile_mp_scoreboard.sv
// Multi-read, dual-write integer register file with optional write-to-read bypass
// and a per-register busy scoreboard for issue-time hazard detection.
module regfile_mp_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RPORTS-1:0]            rvalid,
  input  logic                             wen0,
  input  logic [ADDR_WIDTH-1:0]            waddr0,
  input  logic [DATA_WIDTH-1:0]            wdata0,
  input  logic                             wen1,
  input  logic [ADDR_WIDTH-1:0]            waddr1,
  input  logic [DATA_WIDTH-1:0]            wdata1,
  input  logic                             issue_valid,
  input  logic [ADDR_WIDTH-1:0]            issue_addr,
  output logic                             issue_stall,
  input  logic                             flush,
  output logic [(1<<ADDR_WIDTH)-1:0]       busy,
  output logic [DATA_WIDTH-1:0]            rf [0:(1<<ADDR_WIDTH)-1]
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_nxt;

  // Issue handshake: a reservation is accepted in a cycle where issue_valid=1 and
  // issue_stall=0; while stalled the issuer holds issue_valid/issue_addr unchanged.
  assign issue_stall = issue_valid & busy[issue_addr];

  always_comb begin
    busy_nxt = '0;
    if (!flush) begin
      for (int r = 1; r < DEPTH; r++) begin
        busy_nxt[r] = (issue_valid & ~issue_stall & (issue_addr == ADDR_WIDTH'(r)))
                    | (busy[r] & ~((wen0 & (waddr0 == ADDR_WIDTH'(r)))
                                 | (wen1 & (waddr1 == ADDR_WIDTH'(r)))));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int r = 0; r < DEPTH; r++) rf[r] <= '0;
    end else begin
      busy <= busy_nxt;
      // Entry 0 is never written, so it holds its reset value of zero.
      for (int r = 1; r < DEPTH; r++) begin
        if (wen1 && waddr1 == ADDR_WIDTH'(r))      rf[r] <= wdata1;
        else if (wen0 && waddr0 == ADDR_WIDTH'(r)) rf[r] <= wdata0;
      end
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit0;
    logic                  hit1;
    rdata  = '0;
    rvalid = '0;
    ra     = '0;
    hit0   = 1'b0;
    hit1   = 1'b0;
    for (int k = 0; k < NUM_RPORTS; k++) begin
      ra   = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      // Forwarding is suppressed during reset so outputs read as the cleared array.
      hit1 = (BYPASS != 0) && !rst && wen1 && (waddr1 == ra) && (ra != '0);
      hit0 = (BYPASS != 0) && !rst && wen0 && (waddr0 == ra) && (ra != '0);
      if (hit1)      rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata1;
      else if (hit0) rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata0;
      else           rdata[k*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
      rvalid[k] = (ra == '0) || !busy[ra] || hit0 || hit1;
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: a bypassing and a non-bypassing instance share
// inputs and are compared against an array/bit-vector reference model.
module tb_regfile_mp_scoreboard;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rvalid_b, rvalid_n;
  logic             wen0, wen1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic             issue_valid;
  logic [AW-1:0]    issue_addr;
  logic             stall_b, stall_n;
  logic             flush;
  logic [DEPTH-1:0] busy_b, busy_n;
  logic [DW-1:0]    rf_b [0:DEPTH-1];
  logic [DW-1:0]    rf_n [0:DEPTH-1];

  regfile_mp_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0), .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_stall(stall_b),
    .flush(flush), .busy(busy_b), .rf(rf_b)
  );

  regfile_mp_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rvalid(rvalid_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0), .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_stall(stall_n),
    .flush(flush), .busy(busy_n), .rf(rf_n)
  );

  // Reference model: plain array of register values and a busy bit per register.
  logic [DW-1:0]    ref_rf [0:DEPTH-1];
  logic [DEPTH-1:0] ref_busy;
  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ra_of(input int k);
    return raddr[k*AW +: AW];
  endfunction

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wen1 && waddr1 == a) return wdata1;
    if (byp && wen0 && waddr0 == a) return wdata0;
    return ref_rf[a];
  endfunction

  function automatic logic exp_rv(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b1;
    if (!ref_busy[a]) return 1'b1;
    return byp && ((wen0 && waddr0 == a) || (wen1 && waddr1 == a));
  endfunction

  task automatic idle();
    wen0 = 0; wen1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    issue_valid = 0; issue_addr = '0; flush = 0; raddr = '0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < DEPTH; r++) ref_rf[r] = '0;
    ref_busy = '0;
  endtask

  task automatic check_comb();
    logic exp_stall;
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rdata_byp[%0d]", k), rdata_b[k*DW +: DW], exp_rd(ra_of(k), 1'b1));
      chk($sformatf("rvalid_byp[%0d]", k), rvalid_b[k], exp_rv(ra_of(k), 1'b1));
      chk($sformatf("rdata_nobyp[%0d]", k), rdata_n[k*DW +: DW], exp_rd(ra_of(k), 1'b0));
      chk($sformatf("rvalid_nobyp[%0d]", k), rvalid_n[k], exp_rv(ra_of(k), 1'b0));
    end
    exp_stall = issue_valid && (issue_addr != 0) && ref_busy[issue_addr];
    chk("stall_byp", stall_b, exp_stall);
    chk("stall_nobyp", stall_n, exp_stall);
  endtask

  task automatic check_state();
    chk("busy_byp", busy_b, ref_busy);
    chk("busy_nobyp", busy_n, ref_busy);
    for (int r = 0; r < DEPTH; r++) begin
      chk($sformatf("rf_byp[%0d]", r), rf_b[r], ref_rf[r]);
      chk($sformatf("rf_nobyp[%0d]", r), rf_n[r], ref_rf[r]);
    end
  endtask

  // One clock: check outputs settled from current inputs, then advance model and DUT.
  task automatic step();
    logic [DEPTH-1:0] nb;
    logic             accepted;
    #1;
    check_comb();
    accepted = issue_valid && (issue_addr != 0) && !ref_busy[issue_addr];
    nb = ref_busy;
    if (wen0) nb[waddr0] = 1'b0;
    if (wen1) nb[waddr1] = 1'b0;
    if (accepted) nb[issue_addr] = 1'b1;
    if (flush) nb = '0;
    nb[0] = 1'b0;
    @(posedge clk);
    #1;
    ref_busy = nb;
    if (wen0 && waddr0 != 0) ref_rf[waddr0] = wdata0;
    if (wen1 && waddr1 != 0) ref_rf[waddr1] = wdata1;
    check_state();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Preload, then reset with the clock running.
    for (int r = 1; r <= 4; r++) begin
      idle(); wen0 = 1; waddr0 = AW'(r); wdata0 = 32'h100 + DW'(r);
      issue_valid = 1; issue_addr = AW'(r + 4);
      step();
    end
    idle();
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    chk("rst_held_busy", busy_b, '0);
    chk("rst_held_rdata", rdata_b, '0);
    rst = 1'b0;
    set_ra(0, 5'd1); set_ra(1, 5'd6);
    #1;
    chk("rst_rdata", rdata_b, '0);
    chk("rst_rvalid", rvalid_b, 2'b11);
    check_state();
    step();

    // Write and same-cycle read of register 5.
    idle(); wen0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; set_ra(0, 5'd5);
    #1;
    chk("byp_same_cycle", rdata_b[DW-1:0], 32'hDEADBEEF);
    chk("nobyp_same_cycle", rdata_n[DW-1:0], 32'h0);
    step();
    idle(); set_ra(0, 5'd5);
    #1;
    chk("nobyp_next_cycle", rdata_n[DW-1:0], 32'hDEADBEEF);
    step();

    // Write conflict: port 1 wins.
    idle(); wen0 = 1; wen1 = 1; waddr0 = 5'd7; waddr1 = 5'd7; wdata0 = 32'd1; wdata1 = 32'd2;
    set_ra(0, 5'd7);
    #1;
    chk("conflict_bypass", rdata_b[DW-1:0], 32'd2);
    step();
    chk("conflict_rf7", rf_b[7], 32'd2);

    // Register 0 protection.
    idle(); wen0 = 1; waddr0 = '0; wdata0 = 32'hFFFFFFFF; issue_valid = 1; issue_addr = '0;
    #1;
    chk("x0_stall", stall_b, 1'b0);
    chk("x0_rdata", rdata_b, '0);
    step();
    chk("x0_rf", rf_b[0], 32'h0);
    chk("x0_busy", busy_b[0], 1'b0);

    // Scoreboard flow on register 3.
    idle(); issue_valid = 1; issue_addr = 5'd3;
    step();
    chk("sb_busy3_set", busy_b[3], 1'b1);
    idle(); set_ra(1, 5'd3);
    #1;
    chk("sb_rvalid1_pending", rvalid_b[1], 1'b0);
    issue_valid = 1; issue_addr = 5'd3;
    #1;
    chk("sb_waw_stall", stall_b, 1'b1);
    step();
    chk("sb_busy3_kept", busy_b[3], 1'b1);
    idle(); wen1 = 1; waddr1 = 5'd3; wdata1 = 32'd9; set_ra(1, 5'd3);
    #1;
    chk("sb_wb_rvalid", rvalid_b[1], 1'b1);
    chk("sb_wb_rdata", rdata_b[DW +: DW], 32'd9);
    chk("sb_wb_rvalid_nobyp", rvalid_n[1], 1'b0);
    step();
    chk("sb_busy3_clr", busy_b[3], 1'b0);
    idle(); issue_valid = 1; issue_addr = 5'd3; wen0 = 1; waddr0 = 5'd3; wdata0 = 32'h55;
    step();
    chk("sb_set_beats_clr", busy_b[3], 1'b1);

    // Flush keeps register contents.
    idle(); issue_valid = 1; issue_addr = 5'd4; wen1 = 1; waddr1 = 5'd4; wdata1 = 32'h44;
    step();
    chk("fl_busy_pre", busy_b[4:3], 2'b11);
    idle(); flush = 1; issue_valid = 1; issue_addr = 5'd9; wen0 = 1; waddr0 = 5'd9; wdata0 = 32'h99;
    step();
    chk("fl_busy_zero", busy_b, '0);
    chk("fl_rf3", rf_b[3], 32'h55);
    chk("fl_rf4", rf_b[4], 32'h44);

    // Asynchronous reset between edges.
    idle(); issue_valid = 1; issue_addr = 5'd3;
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async_busy", busy_b, '0);
    chk("async_rf3", rf_b[3], 32'h0);
    chk("async_rf7_nobyp", rf_n[7], 32'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    check_state();

    // Randomised traffic on a small address window to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      wen0        = ($urandom_range(0, 2) != 0);
      wen1        = ($urandom_range(0, 2) == 0);
      waddr0      = AW'($urandom_range(0, 7));
      waddr1      = AW'($urandom_range(0, 7));
      wdata0      = $urandom;
      wdata1      = $urandom;
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_addr  = AW'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 15) == 0);
      set_ra(0, AW'($urandom_range(0, 7)));
      set_ra(1, AW'($urandom_range(0, 7)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
